// File: rtl/llc_flush_ctrl_pkg.sv
// Shared widths, defaults and state encoding for the LLC flush sequencer.
package llc_flush_ctrl_pkg;

   localparam int LLC_SETS     = 16;
   localparam int LLC_WAYS     = 8;
   localparam int LLC_SET_BITS = 4;
   localparam int LLC_WAY_BITS = 3;
   localparam int N_MSHR_FREE  = 16;
   localparam int MSHR_BITS_P1 = 5;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      DRAIN   = 3'd1,
      READ    = 3'd2,
      CHECK   = 3'd3,
      EVICT   = 3'd4,
      ADVANCE = 3'd5,
      DONE    = 3'd6
   } llc_flush_state_t;

endpackage

// File: rtl/llc_flush_ctrl.sv
// LLC flush sequencer: drains MSHRs, walks every (set, way), evicts lines that
// need write-back, and drives the flush-field triggers of the register bank.
module llc_flush_ctrl
   import llc_flush_ctrl_pkg::*;
#(
   parameter int NUM_SETS = LLC_SETS,
   parameter int NUM_WAYS = LLC_WAYS,
   parameter int N_MSHR   = N_MSHR_FREE
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush_req_valid,
   output logic                    flush_req_ready,
   input  logic                    ongoing_flush,
   input  logic [LLC_SET_BITS:0]   flush_set,
   input  logic [LLC_WAY_BITS:0]   flush_way,
   input  logic [MSHR_BITS_P1-1:0] mshr_cnt,
   output logic                    tag_rd_en,
   output logic [LLC_SET_BITS-1:0] tag_rd_set,
   output logic [LLC_WAY_BITS-1:0] tag_rd_way,
   input  logic                    line_needs_evict,
   output logic                    evict_valid,
   input  logic                    evict_ready,
   output logic [LLC_SET_BITS-1:0] evict_set,
   output logic [LLC_WAY_BITS-1:0] evict_way,
   output logic                    set_ongoing_flush,
   output logic                    clr_ongoing_flush,
   output logic                    incr_flush_set,
   output logic                    clr_flush_set,
   output logic                    incr_flush_way,
   output logic                    clr_flush_way,
   output logic                    flush_done,
   output logic                    flush_abort
);

   localparam int SET_W = LLC_SET_BITS + 1;
   localparam int WAY_W = LLC_WAY_BITS + 1;
   localparam logic [SET_W-1:0]        LAST_SET  = SET_W'(NUM_SETS - 1);
   localparam logic [WAY_W-1:0]        LAST_WAY  = WAY_W'(NUM_WAYS - 1);
   localparam logic [MSHR_BITS_P1-1:0] MSHR_FREE = MSHR_BITS_P1'(N_MSHR);

   llc_flush_state_t state_reg, state_next;
   logic [LLC_SET_BITS-1:0] evict_set_reg;
   logic [LLC_WAY_BITS-1:0] evict_way_reg;

   always_comb begin
      state_next        = state_reg;
      flush_req_ready   = 1'b0;
      tag_rd_en         = 1'b0;
      evict_valid       = 1'b0;
      set_ongoing_flush = 1'b0;
      clr_ongoing_flush = 1'b0;
      incr_flush_set    = 1'b0;
      clr_flush_set     = 1'b0;
      incr_flush_way    = 1'b0;
      clr_flush_way     = 1'b0;
      flush_done        = 1'b0;
      flush_abort       = 1'b0;
      case (state_reg)
         IDLE: begin
            flush_req_ready = 1'b1;
            // Triggers go out in the accept cycle so DRAIN already sees ongoing_flush=1.
            if (flush_req_valid && !rst) begin
               set_ongoing_flush = 1'b1;
               clr_flush_set     = 1'b1;
               clr_flush_way     = 1'b1;
               state_next        = DRAIN;
            end
         end
         DRAIN: begin
            if (!ongoing_flush) begin
               flush_abort   = 1'b1;
               clr_flush_set = 1'b1;
               clr_flush_way = 1'b1;
               state_next    = IDLE;
            end else if (mshr_cnt == MSHR_FREE) begin
               state_next = READ;
            end
         end
         READ: begin
            tag_rd_en = 1'b1;
            if (!ongoing_flush) begin
               flush_abort   = 1'b1;
               clr_flush_set = 1'b1;
               clr_flush_way = 1'b1;
               state_next    = IDLE;
            end else begin
               state_next = CHECK;
            end
         end
         CHECK: begin
            if (!ongoing_flush) begin
               flush_abort   = 1'b1;
               clr_flush_set = 1'b1;
               clr_flush_way = 1'b1;
               state_next    = IDLE;
            end else if (line_needs_evict) begin
               state_next = EVICT;
            end else begin
               state_next = ADVANCE;
            end
         end
         EVICT: begin
            // No abort here: the handshake finishes and ADVANCE checks afterwards.
            evict_valid = 1'b1;
            if (evict_ready) begin
               state_next = ADVANCE;
            end
         end
         ADVANCE: begin
            if (!ongoing_flush) begin
               flush_abort   = 1'b1;
               clr_flush_set = 1'b1;
               clr_flush_way = 1'b1;
               state_next    = IDLE;
            end else if (flush_way != LAST_WAY) begin
               incr_flush_way = 1'b1;
               state_next     = READ;
            end else if (flush_set != LAST_SET) begin
               incr_flush_set = 1'b1;
               clr_flush_way  = 1'b1;
               state_next     = READ;
            end else begin
               state_next = DONE;
            end
         end
         DONE: begin
            clr_ongoing_flush = 1'b1;
            clr_flush_set     = 1'b1;
            clr_flush_way     = 1'b1;
            flush_done        = 1'b1;
            state_next        = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign tag_rd_set = tag_rd_en ? flush_set[LLC_SET_BITS-1:0] : '0;
   assign tag_rd_way = tag_rd_en ? flush_way[LLC_WAY_BITS-1:0] : '0;
   assign evict_set  = evict_set_reg;
   assign evict_way  = evict_way_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         evict_set_reg <= '0;
         evict_way_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (state_reg == CHECK && state_next == EVICT) begin
            evict_set_reg <= flush_set[LLC_SET_BITS-1:0];
            evict_way_reg <= flush_way[LLC_WAY_BITS-1:0];
         end
      end
   end

endmodule

// File: tb/tb_llc_flush_ctrl.sv
// Directed bench for llc_flush_ctrl with a behavioural register bank and tag array.
module tb_llc_flush_ctrl;
   import llc_flush_ctrl_pkg::*;

   localparam int NS = 4;
   localparam int NW = 2;
   localparam logic [MSHR_BITS_P1-1:0] MSHR_ALL = MSHR_BITS_P1'(N_MSHR_FREE);

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic flush_req_valid = 1'b0, flush_req_ready;
   logic ongoing_flush;
   logic [LLC_SET_BITS:0] flush_set;
   logic [LLC_WAY_BITS:0] flush_way;
   logic [MSHR_BITS_P1-1:0] mshr_cnt = '0;
   logic tag_rd_en;
   logic [LLC_SET_BITS-1:0] tag_rd_set, evict_set;
   logic [LLC_WAY_BITS-1:0] tag_rd_way, evict_way;
   logic line_needs_evict = 1'b0, evict_valid, evict_ready = 1'b0;
   logic set_ongoing_flush, clr_ongoing_flush, incr_flush_set, clr_flush_set;
   logic incr_flush_way, clr_flush_way, flush_done, flush_abort;
   logic rst_n, force_clr = 1'b0;

   always #5 clk = ~clk;
   assign rst_n = ~rst;

   llc_flush_ctrl #(.NUM_SETS(NS), .NUM_WAYS(NW), .N_MSHR(N_MSHR_FREE)) dut (
      .clk(clk), .rst(rst), .flush_req_valid(flush_req_valid), .flush_req_ready(flush_req_ready),
      .ongoing_flush(ongoing_flush), .flush_set(flush_set), .flush_way(flush_way),
      .mshr_cnt(mshr_cnt), .tag_rd_en(tag_rd_en), .tag_rd_set(tag_rd_set), .tag_rd_way(tag_rd_way),
      .line_needs_evict(line_needs_evict), .evict_valid(evict_valid), .evict_ready(evict_ready),
      .evict_set(evict_set), .evict_way(evict_way), .set_ongoing_flush(set_ongoing_flush),
      .clr_ongoing_flush(clr_ongoing_flush), .incr_flush_set(incr_flush_set),
      .clr_flush_set(clr_flush_set), .incr_flush_way(incr_flush_way), .clr_flush_way(clr_flush_way),
      .flush_done(flush_done), .flush_abort(flush_abort)
   );

   // Register bank stand-in; its reset is active-low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ongoing_flush <= 1'b0;
         flush_set     <= '0;
         flush_way     <= '0;
      end else begin
         if (set_ongoing_flush) ongoing_flush <= 1'b1;
         else if (clr_ongoing_flush || force_clr) ongoing_flush <= 1'b0;
         if (clr_flush_set) flush_set <= '0;
         else if (incr_flush_set) flush_set <= flush_set + 1'b1;
         if (clr_flush_way) flush_way <= '0;
         else if (incr_flush_way) flush_way <= flush_way + 1'b1;
      end
   end

   int tests = 0, fails = 0;
   bit dirty [16][8];
   int ev_delay = 0, ev_cnt = 0, ev_hold = 0, acc_cnt = 0;
   bit req_pulse = 0, req_hold = 0, accepted = 0, prev_rd = 0;
   bit abort_mode = 0, abort_fired = 0, force_pending = 0, ev_unstable = 0;
   logic [LLC_SET_BITS-1:0] prev_set = '0, ev_set_seen = '0;
   logic [LLC_WAY_BITS-1:0] prev_way = '0, ev_way_seen = '0;
   logic [MSHR_BITS_P1-1:0] mshr_val = MSHR_ALL;
   int rd_log[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] outs_vec();
      return {evict_set, evict_way, tag_rd_set, tag_rd_way, tag_rd_en, evict_valid,
              set_ongoing_flush, clr_ongoing_flush, incr_flush_set, clr_flush_set,
              incr_flush_way, clr_flush_way, flush_done, flush_abort, flush_req_ready};
   endfunction

   // One clock cycle: drive inputs at the falling edge, sample outputs 1ns later.
   task automatic tick();
      @(negedge clk);
      flush_req_valid  = req_pulse | req_hold;
      mshr_cnt         = mshr_val;
      line_needs_evict = prev_rd & dirty[prev_set][prev_way];
      evict_ready      = evict_valid && (ev_cnt >= ev_delay);
      force_clr        = force_pending;
      force_pending    = 0;
      #1;
      accepted = flush_req_valid && flush_req_ready;
      if (accepted) begin
         req_pulse = 0;
         acc_cnt++;
      end
      prev_rd = tag_rd_en; prev_set = tag_rd_set; prev_way = tag_rd_way;
      if (tag_rd_en) rd_log.push_back(int'(tag_rd_set) * NW + int'(tag_rd_way));
      if (evict_valid) begin
         if (ev_cnt == 0) begin
            ev_set_seen = evict_set; ev_way_seen = evict_way;
         end else if (evict_set != ev_set_seen || evict_way != ev_way_seen) begin
            ev_unstable = 1;
         end
         ev_cnt++;
         ev_hold = ev_cnt;
      end else begin
         ev_cnt = 0;
      end
      if (abort_mode && tag_rd_en && tag_rd_set == 1 && !abort_fired) begin
         force_pending = 1;
         abort_fired   = 1;
      end
   endtask

   // Requests a flush and counts cycles from the accept cycle (=1) to done/abort.
   task automatic run_flush(input int stall, output int cnt, output bit got_done,
                            output bit got_abort, output int first_rd);
      bit started = 0;
      cnt = 0; got_done = 0; got_abort = 0; first_rd = 0;
      rd_log.delete();
      mshr_val  = (stall > 0) ? MSHR_ALL - 2 : MSHR_ALL;
      req_pulse = 1;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (!started && accepted) started = 1;
         if (started) begin
            cnt++;
            if (tag_rd_en && first_rd == 0) first_rd = cnt;
            if (cnt == stall + 1) mshr_val = MSHR_ALL;
            if (flush_done || flush_abort) begin
               got_done  = flush_done;
               got_abort = flush_abort;
               break;
            end
         end
      end
      $display("[TB] flush: cycles=%0d done=%0b abort=%0b reads=%0d first_read=%0d",
               cnt, got_done, got_abort, rd_log.size(), first_rd);
   endtask

   initial begin
      int cnt, frd, cnt2, acc_before;
      bit gd, ga, seen;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk("reset_outputs", outs_vec(), 32'h1);
      chk("reset_bank", {ongoing_flush, flush_set, flush_way}, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // Clean flush
      run_flush(0, cnt, gd, ga, frd);
      chk("clean_cycles", cnt, 27);
      chk("clean_done", {gd, ga}, 2'b10);
      chk("clean_reads", rd_log.size(), 8);
      for (int i = 0; i < rd_log.size(); i++) chk($sformatf("clean_read_%0d", i), rd_log[i], i);
      tick();
      chk("clean_bank_after", {ongoing_flush, flush_set, flush_way}, 32'h0);
      chk("clean_idle_after", {flush_done, flush_req_ready}, 2'b01);

      // Drain stall
      run_flush(10, cnt, gd, ga, frd);
      chk("stall_first_read", frd, 13);
      chk("stall_cycles", cnt, 37);
      chk("stall_done", {gd, ga}, 2'b10);

      // Eviction backpressure on line (2,1)
      dirty[2][1] = 1; ev_delay = 5; ev_unstable = 0; ev_hold = 0;
      run_flush(0, cnt, gd, ga, frd);
      chk("evict_hold", ev_hold, 6);
      chk("evict_setway", {ev_set_seen, ev_way_seen}, {4'd2, 3'd1});
      chk("evict_stable", ev_unstable, 0);
      chk("evict_cycles", cnt, 33);
      chk("evict_done", {gd, ga}, 2'b10);
      dirty[2][1] = 0; ev_delay = 0;
      tick();

      // Abort while walking set 1
      abort_mode = 1; abort_fired = 0;
      run_flush(0, cnt, gd, ga, frd);
      abort_mode = 0;
      chk("abort_flags", {gd, ga}, 2'b01);
      chk("abort_cycle", cnt, 11);
      chk("abort_reads", rd_log.size(), 3);
      tick();
      chk("abort_idle", {flush_abort, flush_done, flush_req_ready}, 3'b001);
      chk("abort_bank", {ongoing_flush, flush_set, flush_way}, 32'h0);

      // Reset asserted while an eviction is pending
      dirty[0][0] = 1; ev_delay = 1000; seen = 0;
      req_pulse = 1;
      for (int i = 0; i < 50 && !seen; i++) begin
         tick();
         seen = evict_valid;
      end
      chk("rstmid_evict_seen", seen, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("rstmid_outputs", outs_vec(), 32'h1);
      chk("rstmid_bank", {ongoing_flush, flush_set, flush_way}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      dirty[0][0] = 0; ev_delay = 0; ev_cnt = 0; prev_rd = 0;
      run_flush(0, cnt, gd, ga, frd);
      chk("rstmid_reflush_cycles", cnt, 27);
      chk("rstmid_reflush_done", {gd, ga}, 2'b10);

      // Request held high across a whole flush
      acc_before = acc_cnt;
      req_hold = 1;
      run_flush(0, cnt, gd, ga, frd);
      chk("hold_cycles", cnt, 27);
      chk("hold_single_accept", acc_cnt - acc_before, 1);
      tick();
      chk("hold_second_accept", {accepted, set_ongoing_flush}, 2'b11);
      req_hold = 0;
      cnt2 = 1; gd = 0;
      for (int i = 0; i < 100 && !gd; i++) begin
         tick();
         cnt2++;
         gd = flush_done;
      end
      $display("[TB] flush: second held-request flush cycles=%0d done=%0b", cnt2, gd);
      chk("hold_second_cycles", cnt2, 27);
      chk("hold_accepts_total", acc_cnt - acc_before, 2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
